// File: rtl/lw_sha_pkg.sv
// Shared types for the lightweight SHA/HMAC subsystem: arbiter FSM states,
// opcode field layout and digest geometry.
package lw_sha_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_BUSY  = 2'd1,
    ARB_DONE  = 2'd2,
    ARB_ABORT = 2'd3
  } arb_state_e;

  // Bit 3 of the opcode selects HMAC; it is also the top bit of the field.
  localparam int OPCODE_HMAC_BIT = 3;
  localparam int OPCODE_W        = OPCODE_HMAC_BIT + 1;
  localparam int HASH_WORDS      = 8;

endpackage

// File: rtl/defines.sv
// Global word-width define shared by the SHA/HMAC datapath files.
`ifndef HMAC_DEFINES_SV
`define HMAC_DEFINES_SV
`define WORD_SIZE 32
`endif

// File: rtl/hmac_arbiter_rr.sv
// Round-robin requester selection: first asserted request at or after ptr,
// wrapping at NUM_REQ, returned as a one-hot grant.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant
);

  always_comb begin
    logic             found;
    logic [PTR_W:0]   pos;
    grant = '0;
    found = 1'b0;
    pos   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      pos = {1'b0, ptr} + (PTR_W + 1)'(k);
      if (pos >= (PTR_W + 1)'(NUM_REQ)) begin
        pos = pos - (PTR_W + 1)'(NUM_REQ);
      end
      if (!found && req[pos[PTR_W-1:0]]) begin
        grant[pos[PTR_W-1:0]] = 1'b1;
        found                 = 1'b1;
      end
    end
  end

endmodule

// File: rtl/hmac_arbiter.sv
// Shares one SHA/HMAC engine between NUM_REQ requesters with round-robin grant.
// Optional stall watchdog enabled by defining HMAC_ARB_TIMEOUT_EN.
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif

module hmac_arbiter
  import lw_sha_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                                  clk_i,
  input  logic                                  areset_i,
  input  logic [NUM_REQ-1:0]                    req_start_i,
  input  logic [NUM_REQ-1:0]                    req_last_i,
  input  logic [NUM_REQ-1:0]                    req_data_valid_i,
  input  logic [NUM_REQ-1:0]                    req_key_valid_i,
  input  logic [NUM_REQ-1:0]                    req_abort_i,
  input  logic [NUM_REQ-1:0][`WORD_SIZE-1:0]    req_data_i,
  input  logic [NUM_REQ-1:0][`WORD_SIZE-1:0]    req_key_i,
  input  logic [NUM_REQ-1:0][OPCODE_W-1:0]      req_opcode_i,
  output logic [NUM_REQ-1:0]                    req_ready_o,
  output logic [NUM_REQ-1:0]                    req_key_ready_o,
  output logic [NUM_REQ-1:0]                    req_grant_o,
  output logic [NUM_REQ-1:0]                    req_done_o,
  output logic [NUM_REQ-1:0]                    req_err_o,
  output logic [HASH_WORDS-1:0][`WORD_SIZE-1:0] hash_o,
  output logic                                  eng_start_o,
  output logic                                  eng_abort_o,
  output logic                                  eng_last_o,
  output logic                                  eng_data_valid_o,
  output logic                                  eng_key_valid_o,
  output logic [`WORD_SIZE-1:0]                 eng_data_o,
  output logic [`WORD_SIZE-1:0]                 eng_key_o,
  output logic [OPCODE_W-1:0]                   eng_opcode_o,
  input  logic                                  eng_ready_i,
  input  logic                                  eng_key_ready_i,
  input  logic                                  eng_core_ready_i,
  input  logic                                  eng_done_i,
  input  logic                                  eng_fault_i,
  input  logic [HASH_WORDS-1:0][`WORD_SIZE-1:0] eng_hash_i
);

  localparam int PTR_W = $clog2(NUM_REQ);

  arb_state_e         state_q;
  logic [PTR_W-1:0]   g_q;
  logic [PTR_W-1:0]   ptr_q;
  logic [PTR_W-1:0]   sel_idx;
  logic [NUM_REQ-1:0] cand;
  logic [NUM_REQ-1:0] sel_onehot;
  logic [OPCODE_W-1:0] opcode_q;
  logic               busy;
  logic               abort_g;
  logic               timeout_hit;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] cur);
    if (cur == PTR_W'(NUM_REQ - 1)) begin
      return '0;
    end
    return cur + PTR_W'(1);
  endfunction

  assign cand    = req_start_i & req_data_valid_i;
  assign busy    = (state_q == ARB_BUSY);
  // Only the granted requester may abort; others are masked out here.
  assign abort_g = busy & req_abort_i[g_q];

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr (
    .req   (cand),
    .ptr   (ptr_q),
    .grant (sel_onehot)
  );

  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (sel_onehot[i]) begin
        sel_idx = PTR_W'(i);
      end
    end
  end

`ifdef HMAC_ARB_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0] stall_q;
  logic            handshake;

  assign handshake = busy & ((req_data_valid_i[g_q] & eng_ready_i) |
                             (req_key_valid_i[g_q]  & eng_key_ready_i));
  // Fires during the TIMEOUT_CYCLES-th consecutive stalled BUSY cycle;
  // a completing or aborting message takes precedence.
  assign timeout_hit = busy & ~eng_fault_i & ~abort_g & ~eng_done_i & ~handshake &
                       (stall_q == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i or posedge areset_i) begin
    if (areset_i) begin
      stall_q <= '0;
    end else if (!busy || handshake || timeout_hit) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_q + TO_W'(1);
    end
  end
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;

  assign timeout_hit = 1'b0;
`endif

  // Control FSM; done/err pulses and the digest are registered on the
  // transition out of BUSY so they appear one cycle after the engine event.
  always_ff @(posedge clk_i or posedge areset_i) begin
    if (areset_i) begin
      state_q      <= ARB_IDLE;
      g_q          <= '0;
      ptr_q        <= '0;
      opcode_q     <= '0;
      req_done_o   <= '0;
      req_err_o    <= '0;
      hash_o       <= '0;
    end else begin
      req_done_o <= '0;
      req_err_o  <= '0;
      if (eng_fault_i) begin
        if (busy) begin
          req_err_o[g_q] <= 1'b1;
        end
        state_q <= ARB_IDLE;
      end else begin
        case (state_q)
          ARB_IDLE: begin
            if (eng_core_ready_i && (|cand)) begin
              g_q      <= sel_idx;
              opcode_q <= req_opcode_i[sel_idx];
              state_q  <= ARB_BUSY;
            end
          end
          ARB_BUSY: begin
            if (abort_g) begin
              ptr_q   <= next_ptr(g_q);
              state_q <= ARB_ABORT;
            end else if (eng_done_i) begin
              hash_o          <= eng_hash_i;
              req_done_o[g_q] <= 1'b1;
              ptr_q           <= next_ptr(g_q);
              state_q         <= ARB_DONE;
            end else if (timeout_hit) begin
              req_err_o[g_q] <= 1'b1;
              ptr_q          <= next_ptr(g_q);
              state_q        <= ARB_IDLE;
            end
          end
          ARB_DONE:  state_q <= ARB_IDLE;
          ARB_ABORT: state_q <= ARB_IDLE;
          default:   state_q <= ARB_IDLE;
        endcase
      end
    end
  end

  // Zero-latency routing between the granted requester and the engine.
  always_comb begin
    req_ready_o      = '0;
    req_key_ready_o  = '0;
    req_grant_o      = '0;
    eng_start_o      = 1'b0;
    eng_last_o       = 1'b0;
    eng_data_valid_o = 1'b0;
    eng_key_valid_o  = 1'b0;
    eng_data_o       = '0;
    eng_key_o        = '0;
    if (busy) begin
      req_grant_o[g_q]     = 1'b1;
      req_ready_o[g_q]     = eng_ready_i;
      req_key_ready_o[g_q] = eng_key_ready_i;
      eng_start_o          = req_start_i[g_q];
      eng_last_o           = req_last_i[g_q];
      eng_data_valid_o     = req_data_valid_i[g_q];
      eng_key_valid_o      = req_key_valid_i[g_q];
      eng_data_o           = req_data_i[g_q];
      eng_key_o            = req_key_i[g_q];
    end
  end

  assign eng_abort_o  = ~areset_i & (eng_fault_i | abort_g | timeout_hit);
  assign eng_opcode_o = opcode_q;

endmodule

// File: tb/tb_hmac_arbiter.sv
// Directed + randomized bench for hmac_arbiter against a transaction-level model.
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif

module tb_hmac_arbiter;

  localparam int N  = 3;
  localparam int W  = `WORD_SIZE;
  localparam int TO = 16;
  localparam int HW = 8 * W;

  logic                   clk_i;
  logic                   areset_i;
  logic [N-1:0]           req_start_i, req_last_i, req_data_valid_i, req_key_valid_i, req_abort_i;
  logic [N-1:0][W-1:0]    req_data_i, req_key_i;
  logic [N-1:0][3:0]      req_opcode_i;
  logic [N-1:0]           req_ready_o, req_key_ready_o, req_grant_o, req_done_o, req_err_o;
  logic [7:0][W-1:0]      hash_o;
  logic                   eng_start_o, eng_abort_o, eng_last_o, eng_data_valid_o, eng_key_valid_o;
  logic [W-1:0]           eng_data_o, eng_key_o;
  logic [3:0]             eng_opcode_o;
  logic                   eng_ready_i, eng_key_ready_i, eng_core_ready_i, eng_done_i, eng_fault_i;
  logic [7:0][W-1:0]      eng_hash_i;

  hmac_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk_i), .areset_i(areset_i),
    .req_start_i(req_start_i), .req_last_i(req_last_i), .req_data_valid_i(req_data_valid_i),
    .req_key_valid_i(req_key_valid_i), .req_abort_i(req_abort_i),
    .req_data_i(req_data_i), .req_key_i(req_key_i), .req_opcode_i(req_opcode_i),
    .req_ready_o(req_ready_o), .req_key_ready_o(req_key_ready_o), .req_grant_o(req_grant_o),
    .req_done_o(req_done_o), .req_err_o(req_err_o), .hash_o(hash_o),
    .eng_start_o(eng_start_o), .eng_abort_o(eng_abort_o), .eng_last_o(eng_last_o),
    .eng_data_valid_o(eng_data_valid_o), .eng_key_valid_o(eng_key_valid_o),
    .eng_data_o(eng_data_o), .eng_key_o(eng_key_o), .eng_opcode_o(eng_opcode_o),
    .eng_ready_i(eng_ready_i), .eng_key_ready_i(eng_key_ready_i), .eng_core_ready_i(eng_core_ready_i),
    .eng_done_i(eng_done_i), .eng_fault_i(eng_fault_i), .eng_hash_i(eng_hash_i)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int checks;
  int failures;

  // Transaction-level model: mode 0 = idle, 1 = serving m_owner,
  // 2 = one-cycle wind-down after a completed or aborted message.
  int                m_mode, m_owner, m_ptr, m_stall;
  logic [3:0]        m_opcode;
  logic [7:0][W-1:0] m_hash;
  logic [N-1:0]      m_done, m_err;

  task automatic chk(input string tag, input logic [HW-1:0] obs, input logic [HW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit owner_handshake();
    if (m_mode != 1) return 1'b0;
    return (req_data_valid_i[m_owner] && eng_ready_i) || (req_key_valid_i[m_owner] && eng_key_ready_i);
  endfunction

  function automatic bit timeout_now();
`ifdef HMAC_ARB_TIMEOUT_EN
    return (m_mode == 1) && !eng_fault_i && !req_abort_i[m_owner] && !eng_done_i &&
           !owner_handshake() && (m_stall == TO - 1);
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_reset();
    m_mode = 0; m_owner = 0; m_ptr = 0; m_stall = 0;
    m_opcode = '0; m_hash = '0; m_done = '0; m_err = '0;
  endtask

  task automatic model_tick();
    logic [N-1:0] nd, ne;
    bit stay_busy, hs, to;
    int c;
    nd = '0; ne = '0;
    hs = owner_handshake();
    to = timeout_now();
    stay_busy = 1'b0;
    if (eng_fault_i) begin
      if (m_mode == 1) ne[m_owner] = 1'b1;
      m_mode = 0;
    end else if (m_mode == 1 && req_abort_i[m_owner]) begin
      m_ptr = (m_owner + 1) % N; m_mode = 2;
    end else if (m_mode == 1 && eng_done_i) begin
      m_hash = eng_hash_i; nd[m_owner] = 1'b1; m_ptr = (m_owner + 1) % N; m_mode = 2;
    end else if (to) begin
      ne[m_owner] = 1'b1; m_ptr = (m_owner + 1) % N; m_mode = 0;
    end else if (m_mode == 1) begin
      stay_busy = 1'b1;
    end else if (m_mode == 2) begin
      m_mode = 0;
    end else if (eng_core_ready_i) begin
      for (int k = 0; k < N; k++) begin
        c = (m_ptr + k) % N;
        if (m_mode == 0 && req_start_i[c] && req_data_valid_i[c]) begin
          m_owner = c; m_opcode = req_opcode_i[c]; m_mode = 1;
        end
      end
    end
    m_stall = (stay_busy && !hs) ? m_stall + 1 : 0;
    m_done = nd;
    m_err  = ne;
  endtask

  task automatic check_all(input string tag);
    logic [N-1:0] eg, er, ek;
    bit b;
    b = (m_mode == 1);
    eg = '0; er = '0; ek = '0;
    if (b) begin
      eg[m_owner] = 1'b1; er[m_owner] = eng_ready_i; ek[m_owner] = eng_key_ready_i;
    end
    chk({tag, ":grant"}, req_grant_o, eg);
    chk({tag, ":ready"}, req_ready_o, er);
    chk({tag, ":kready"}, req_key_ready_o, ek);
    chk({tag, ":done"}, req_done_o, m_done);
    chk({tag, ":err"}, req_err_o, m_err);
    chk({tag, ":hash"}, hash_o, m_hash);
    chk({tag, ":opcode"}, eng_opcode_o, m_opcode);
    chk({tag, ":abort"}, eng_abort_o,
        eng_fault_i | (b & req_abort_i[m_owner]) | timeout_now());
    chk({tag, ":start"}, eng_start_o, b ? req_start_i[m_owner] : 1'b0);
    chk({tag, ":last"}, eng_last_o, b ? req_last_i[m_owner] : 1'b0);
    chk({tag, ":dvalid"}, eng_data_valid_o, b ? req_data_valid_i[m_owner] : 1'b0);
    chk({tag, ":kvalid"}, eng_key_valid_o, b ? req_key_valid_i[m_owner] : 1'b0);
    chk({tag, ":data"}, eng_data_o, b ? req_data_i[m_owner] : '0);
    chk({tag, ":key"}, eng_key_o, b ? req_key_i[m_owner] : '0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ":grant"}, req_grant_o, '0);
    chk({tag, ":ready"}, req_ready_o, '0);
    chk({tag, ":kready"}, req_key_ready_o, '0);
    chk({tag, ":done"}, req_done_o, '0);
    chk({tag, ":err"}, req_err_o, '0);
    chk({tag, ":hash"}, hash_o, '0);
    chk({tag, ":eng"}, {eng_start_o, eng_abort_o, eng_last_o, eng_data_valid_o, eng_key_valid_o}, '0);
    chk({tag, ":data"}, eng_data_o, '0);
    chk({tag, ":key"}, eng_key_o, '0);
    chk({tag, ":opcode"}, eng_opcode_o, '0);
  endtask

  // One clock: check against the model mid-cycle, advance model, cross the edge.
  task automatic cycle(input string tag);
    #1;
    check_all(tag);
    model_tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_inputs();
    req_start_i = '0; req_last_i = '0; req_data_valid_i = '0; req_key_valid_i = '0;
    req_abort_i = '0; req_data_i = '0; req_key_i = '0; req_opcode_i = '0;
    eng_ready_i = 1'b0; eng_key_ready_i = 1'b0; eng_core_ready_i = 1'b1;
    eng_done_i = 1'b0; eng_fault_i = 1'b0; eng_hash_i = '0;
  endtask

  task automatic set_req(input int r, input logic st, input logic dv, input logic kv,
                         input logic lst, input logic [3:0] op);
    req_start_i[r] = st; req_data_valid_i[r] = dv; req_key_valid_i[r] = kv;
    req_last_i[r] = lst; req_opcode_i[r] = op;
    req_data_i[r] = W'($urandom); req_key_i[r] = W'($urandom);
  endtask

  task automatic rand_hash();
    for (int i = 0; i < 8; i++) eng_hash_i[i] = W'($urandom);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0][W-1:0] saved_hash;
    logic [7:0][W-1:0] hv;
    checks = 0;
    failures = 0;
    model_reset();

    // Reset with busy-looking stimulus applied: everything must stay at 0.
    clear_inputs();
    areset_i = 1'b1;
    req_start_i = '1; req_data_valid_i = '1; eng_ready_i = 1'b1;
    eng_done_i = 1'b1; eng_fault_i = 1'b1; rand_hash();
    repeat (2) @(posedge clk_i);
    #1;
    check_zero("reset");
    clear_inputs();
    areset_i = 1'b0;

    // Requesters 0 and 1 start together: 0 first, then 1 after done[0].
    set_req(0, 1, 1, 0, 0, 4'($urandom));
    set_req(1, 1, 1, 0, 0, 4'($urandom));
    cycle("r32_idle");
    chk("r32_grant0", req_grant_o, 3'b001);
    for (int i = 0; i < 2; i++) begin
      req_data_i[0] = W'($urandom); eng_ready_i = 1'($urandom);
      cycle("r32_data");
    end
    eng_done_i = 1'b1; rand_hash();
    cycle("r32_done");
    eng_done_i = 1'b0;
    chk("r32_done0", req_done_o, 3'b001);
    set_req(0, 0, 0, 0, 0, 4'h0);
    cycle("r32_post");
    cycle("r32_sel1");
    chk("r32_grant1", req_grant_o, 3'b010);
    eng_done_i = 1'b1; rand_hash();
    cycle("r32_done1");
    eng_done_i = 1'b0;
    clear_inputs();
    cycle("r32_end");

    // Requester 1 alone, HMAC opcode, key word then two data words.
    set_req(1, 1, 1, 0, 0, 4'h8);
    cycle("r33_grant");
    chk("r33_opcode", eng_opcode_o, 4'h8);
    set_req(1, 0, 0, 1, 0, 4'h3);
    for (int i = 0; i < 4; i++) begin
      eng_key_ready_i = 1'($urandom);
      #1;
      chk("r33_kready", req_key_ready_o, {1'b0, eng_key_ready_i, 1'b0});
      cycle("r33_key");
    end
    eng_key_ready_i = 1'b0;
    eng_ready_i = 1'b1;
    set_req(1, 0, 1, 0, 0, 4'h3);
    cycle("r33_w1");
    set_req(1, 0, 1, 0, 1, 4'h3);
    cycle("r33_w2");
    chk("r33_opcode_hold", eng_opcode_o, 4'h8);
    set_req(1, 0, 0, 0, 0, 4'h3);
    eng_done_i = 1'b1; rand_hash(); hv = eng_hash_i;
    cycle("r33_done");
    eng_done_i = 1'b0; eng_hash_i = '0;
    chk("r33_done", req_done_o, 3'b010);
    chk("r33_hash", hash_o, hv);
    cycle("r33_post");
    chk("r33_done_once", req_done_o, 3'b000);

    // Requester 0 aborts at its third data word; 1 keeps requesting.
    set_req(0, 1, 1, 0, 0, 4'($urandom));
    set_req(1, 1, 1, 0, 0, 4'($urandom));
    eng_ready_i = 1'b1;
    cycle("r34_grant");
    chk("r34_grant0", req_grant_o, 3'b001);
    req_data_i[0] = W'($urandom);
    cycle("r34_w1");
    req_data_i[0] = W'($urandom);
    req_abort_i[1] = 1'b1;
    #1;
    chk("r22_foreign_abort", eng_abort_o, 1'b0);
    cycle("r34_w2");
    req_abort_i[1] = 1'b0;
    req_data_i[0] = W'($urandom);
    req_abort_i[0] = 1'b1;
    #1;
    chk("r34_abort_comb", eng_abort_o, 1'b1);
    cycle("r34_w3");
    chk("r34_no_done", req_done_o, 3'b000);
    req_abort_i[0] = 1'b0;
    cycle("r34_post");
    cycle("r34_sel");
    chk("r34_ptr1_grant", req_grant_o, 3'b010);

    // Done and abort from the granted requester in the same cycle.
    saved_hash = m_hash;
    eng_done_i = 1'b1; rand_hash();
    req_abort_i[1] = 1'b1;
    cycle("r36_both");
    chk("r36_hash_kept", hash_o, saved_hash);
    chk("r36_no_done", req_done_o, 3'b000);
    clear_inputs();
    cycle("r36_post");

    // Randomized traffic against the model.
    for (int n = 0; n < 80; n++) begin
      req_start_i = N'($urandom); req_data_valid_i = N'($urandom) | N'($urandom);
      req_key_valid_i = N'($urandom); req_last_i = N'($urandom);
      for (int r = 0; r < N; r++) begin
        req_abort_i[r] = ($urandom_range(0, 11) == 0);
        req_data_i[r] = W'($urandom); req_key_i[r] = W'($urandom);
        req_opcode_i[r] = 4'($urandom);
      end
      eng_ready_i = 1'($urandom); eng_key_ready_i = 1'($urandom);
      eng_core_ready_i = ($urandom_range(0, 7) != 0);
      eng_done_i = ($urandom_range(0, 5) == 0);
      eng_fault_i = ($urandom_range(0, 39) == 0);
      rand_hash();
      cycle("rnd");
    end
    clear_inputs();
    eng_done_i = 1'b1; rand_hash();
    cycle("rnd_flush");
    clear_inputs();
    repeat (2) cycle("rnd_idle");

    // Reset in the middle of requester 2's message.
    set_req(2, 1, 1, 0, 0, 4'($urandom));
    eng_ready_i = 1'b1;
    cycle("r37_grant");
    chk("r37_grant2", req_grant_o, 3'b100);
    req_data_i[2] = W'($urandom);
    cycle("r37_data");
    areset_i = 1'b1;
    #1;
    check_zero("r37_rst");
    model_reset();
    @(posedge clk_i);
    #1;
    areset_i = 1'b0;
    set_req(0, 1, 1, 0, 0, 4'($urandom));
    set_req(1, 1, 1, 0, 0, 4'($urandom));
    set_req(2, 1, 1, 0, 0, 4'($urandom));
    cycle("r37_sel");
    chk("r37_grant0", req_grant_o, 3'b001);
    eng_done_i = 1'b1; rand_hash();
    cycle("r37_done");
    clear_inputs();
    cycle("r37_post");

`ifdef HMAC_ARB_TIMEOUT_EN
    // Requester 0 offers data the engine never accepts.
    set_req(0, 1, 1, 0, 0, 4'($urandom));
    eng_ready_i = 1'b0;
    cycle("to_grant");
    for (int k = 1; k < TO; k++) begin
      #1;
      chk("to_no_abort", eng_abort_o, 1'b0);
      cycle("to_stall");
    end
    #1;
    chk("to_abort", eng_abort_o, 1'b1);
    cycle("to_hit");
    chk("to_err", req_err_o, 3'b001);
    chk("to_idle_grant", req_grant_o, 3'b000);
    clear_inputs();
    cycle("to_end");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hmac_arbiter.md
HMAC_ARBITER -- requirements
Module: hmac_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 2, number of requester channels (2..8).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1024, stall limit used only when HMAC_ARB_TIMEOUT_EN is defined.
REQ-003 SHALL have port clk_i  in  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port areset_i  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports req_start_i, req_last_i, req_data_valid_i, req_key_valid_i, req_abort_i  in  NUM_REQ  per-requester engine controls.
REQ-006 SHALL have ports req_data_i, req_key_i  in  NUM_REQ x WORD_SIZE  per-requester message and key words.
REQ-007 SHALL have port req_opcode_i  in  NUM_REQ x 4  per-requester opcode; bit 3 selects HMAC.
REQ-008 SHALL have ports req_ready_o, req_key_ready_o, req_grant_o, req_done_o, req_err_o  out  NUM_REQ  per-requester status.
REQ-009 SHALL have port hash_o  out  8 x WORD_SIZE  last completed digest, shared by all requesters.
REQ-010 SHALL have ports eng_start_o, eng_abort_o, eng_last_o, eng_data_valid_o, eng_key_valid_o  out  1  engine controls.
REQ-011 SHALL have ports eng_data_o, eng_key_o  out  WORD_SIZE, and eng_opcode_o  out  4, driving the engine.
REQ-012 SHALL have ports eng_ready_i, eng_key_ready_i, eng_core_ready_i, eng_done_i, eng_fault_i  in  1, and eng_hash_i  in  8 x WORD_SIZE.

Function
REQ-013 SHALL implement FSM IDLE -> BUSY -> (DONE | ABORT) -> IDLE, with the current grant index g held in a register.
REQ-014 In IDLE with eng_core_ready_i=1, SHALL select as g the first requester with req_start_i=1 and req_data_valid_i=1, searching round-robin from priority pointer ptr; the FSM enters BUSY on the next edge.
REQ-015 SHALL latch req_opcode_i[g] at grant; eng_opcode_o SHALL hold it for the whole message.
REQ-016 In BUSY, eng_start_o, eng_last_o, eng_data_valid_o, eng_data_o, eng_key_o, eng_key_valid_o SHALL equal the granted requester's inputs, with zero-cycle latency.
REQ-017 In BUSY, req_ready_o[g]=eng_ready_i and req_key_ready_o[g]=eng_key_ready_i; every other requester SHALL see 0 on both.
REQ-018 req_grant_o[g] SHALL be 1 exactly while in BUSY; all grant bits SHALL be 0 in IDLE.
REQ-019 On eng_done_i in BUSY, SHALL capture eng_hash_i into hash_o, pulse req_done_o[g] for 1 cycle, set ptr=(g+1) mod NUM_REQ, and return to IDLE.
REQ-020 On req_abort_i[g] in BUSY, SHALL assert eng_abort_o combinationally, discard the result, and not pulse req_done_o; ptr SHALL advance.
REQ-021 On eng_fault_i=1 in any state, SHALL assert eng_abort_o for 1 cycle, pulse req_err_o[g] if in BUSY, and go to IDLE.
REQ-022 Abort requests from non-granted requesters SHALL be ignored.
REQ-023 If eng_done_i and req_abort_i[g] rise in the same cycle, abort SHALL win: hash_o is unchanged and no done pulse is issued.
REQ-024 Outside BUSY, all eng_* outputs except eng_abort_o and eng_opcode_o SHALL be 0.

Reset
REQ-025 While areset_i=1: FSM=IDLE, ptr=0, g=0, hash_o=0, every req_*_o=0, every eng_*_o=0.
REQ-026 Reset asserted mid-message SHALL drop the grant immediately with no done or err pulse; the engine receives its own reset.

Configuration
REQ-027 With macro HMAC_ARB_TIMEOUT_EN defined, a counter SHALL count BUSY cycles with no data or key handshake and clear on each handshake.
REQ-028 When that counter reaches TIMEOUT_CYCLES, SHALL pulse eng_abort_o for 1 cycle, pulse req_err_o[g], advance ptr, and go to IDLE.
REQ-029 Without HMAC_ARB_TIMEOUT_EN, the counter SHALL be absent and req_err_o SHALL be driven only by eng_fault_i.

Structure
REQ-030 The FSM state enum and the opcode HMAC bit index SHALL live in lw_sha_pkg; WORD_SIZE SHALL come from defines.sv.
REQ-031 Round-robin selection SHALL be a sub-module rr_arbiter (inputs: request vector, ptr; output: one-hot grant).

Verification
REQ-032 Requesters 0 and 1 start together from reset -> grant 0 first, then grant 1 after req_done_o[0].
REQ-033 Only requester 1 requests, opcode 4'h8, key and 2 data words -> req_key_ready_o[1] follows eng_key_ready_i, req_done_o[1] pulses once, hash_o=eng_hash_i.
REQ-034 Requester 0 aborts at its 3rd data word -> eng_abort_o=1 the same cycle, no done pulse, ptr=1.
REQ-035 Timeout build with TIMEOUT_CYCLES=16, requester stalls -> req_err_o pulses at stall cycle 16 and the FSM returns to IDLE.
REQ-036 eng_done_i and req_abort_i[g] in the same cycle -> hash_o unchanged, no req_done_o pulse.
REQ-037 areset_i asserted mid-message -> all outputs 0 the same cycle; the next request is granted to requester 0.
